// File: rtl/jelly_ram_to_wishbone.sv
// rtl/jelly_ram_to_wishbone.sv - single-outstanding command port to classic Wishbone master bridge
module jelly_ram_to_wishbone #(
    parameter int WB_ADR_WIDTH  = 12,
    parameter int WB_DAT_WIDTH  = 32,
    parameter int WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
    parameter int TIMEOUT_WIDTH = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    s_cmd_valid,
    output logic                    s_cmd_ready,
    input  logic                    s_cmd_we,
    input  logic [WB_ADR_WIDTH-1:0] s_cmd_addr,
    input  logic [WB_DAT_WIDTH-1:0] s_cmd_wdata,
    input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,

    output logic                    m_rsp_valid,
    input  logic                    m_rsp_ready,
    output logic [WB_DAT_WIDTH-1:0] m_rsp_rdata,
    output logic                    m_rsp_err,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
    output logic                    m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam bit                     TO_EN   = (TIMEOUT != 0);
    localparam int                     TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TO_CMP = TIMEOUT_WIDTH'(TO_LAST);

    state_t                    state, state_next;
    logic [TIMEOUT_WIDTH-1:0]  counter, counter_next;
    logic                      cmd_ready_next;
    logic                      rsp_valid_next;
    logic [WB_DAT_WIDTH-1:0]   rsp_rdata_next;
    logic                      rsp_err_next;
    logic [WB_ADR_WIDTH-1:0]   wb_adr_next;
    logic [WB_DAT_WIDTH-1:0]   wb_dat_next;
    logic                      wb_we_next;
    logic [WB_SEL_WIDTH-1:0]   wb_sel_next;
    logic                      wb_stb_next;

    always_comb begin
        state_next     = state;
        counter_next   = counter;
        cmd_ready_next = s_cmd_ready;
        rsp_valid_next = m_rsp_valid;
        rsp_rdata_next = m_rsp_rdata;
        rsp_err_next   = m_rsp_err;
        wb_adr_next    = m_wb_adr_o;
        wb_dat_next    = m_wb_dat_o;
        wb_we_next     = m_wb_we_o;
        wb_sel_next    = m_wb_sel_o;
        wb_stb_next    = m_wb_stb_o;

        case (state)
            ST_IDLE: begin
                // ready comes up one edge after reset release, then stays high while idle
                cmd_ready_next = 1'b1;
                if (s_cmd_valid && s_cmd_ready) begin
                    cmd_ready_next = 1'b0;
                    wb_stb_next    = 1'b1;
                    wb_adr_next    = s_cmd_addr;
                    wb_dat_next    = s_cmd_wdata;
                    wb_we_next     = s_cmd_we;
                    wb_sel_next    = s_cmd_sel;
                    counter_next   = '0;
                    state_next     = ST_BUS;
                end
            end
            ST_BUS: begin
                if (m_wb_ack_i) begin
                    wb_stb_next    = 1'b0;
                    rsp_rdata_next = m_wb_we_o ? '0 : m_wb_dat_i;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RESP;
                end else if (TO_EN && counter == TO_CMP) begin
                    wb_stb_next    = 1'b0;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = ST_RESP;
                end else if (counter != '1) begin
                    counter_next = counter + 1'b1;
                end
            end
            ST_RESP: begin
                if (m_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = '0;
                    cmd_ready_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            s_cmd_ready <= 1'b0;
            m_rsp_valid <= 1'b0;
            m_rsp_rdata <= '0;
            m_rsp_err   <= 1'b0;
            m_wb_adr_o  <= '0;
            m_wb_dat_o  <= '0;
            m_wb_we_o   <= 1'b0;
            m_wb_sel_o  <= '0;
            m_wb_stb_o  <= 1'b0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            s_cmd_ready <= cmd_ready_next;
            m_rsp_valid <= rsp_valid_next;
            m_rsp_rdata <= rsp_rdata_next;
            m_rsp_err   <= rsp_err_next;
            m_wb_adr_o  <= wb_adr_next;
            m_wb_dat_o  <= wb_dat_next;
            m_wb_we_o   <= wb_we_next;
            m_wb_sel_o  <= wb_sel_next;
            m_wb_stb_o  <= wb_stb_next;
        end
    end

endmodule
